// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: edit-FSM encodings, field widths,
// field limits and the wrap-around stepping helpers used by the time-set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_EDIT_HOUR = 2'd1,
        ST_EDIT_MIN  = 2'd2,
        ST_COMMIT    = 2'd3
    } edit_state_e;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

    function automatic logic [HOUR_W-1:0] step_hour(input logic [HOUR_W-1:0] h,
                                                    input logic up);
        if (up)
            step_hour = (h == MAX_HOUR) ? '0 : h + 1'b1;
        else
            step_hour = (h == '0) ? MAX_HOUR : h - 1'b1;
    endfunction

    function automatic logic [MIN_W-1:0] step_min(input logic [MIN_W-1:0] m,
                                                  input logic up);
        if (up)
            step_min = (m == MAX_MIN) ? '0 : m + 1'b1;
        else
            step_min = (m == '0) ? MAX_MIN : m - 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a single-cycle
// press pulse on each debounced high-to-low transition of an active-low key.
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronisers idle at the released level so reset never looks like a press.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        press    = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press    = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: debounced keys drive an hours-then-minutes
// edit FSM that issues a one-cycle load strobe and per-field blink blanking.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int BLINK_CYCLES    = 12_500_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              key_mode_n,
    input  logic              key_up_n,
    input  logic              key_down_n,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    output logic              load,
    output logic [HOUR_W-1:0] load_hours,
    output logic [MIN_W-1:0]  load_minutes,
    output logic              editing,
    output logic              blank_hours,
    output logic              blank_minutes
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // One blink period spans two half-periods: visible then blank.
    localparam int BL_W = $clog2(2 * BLINK_CYCLES);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(2 * BLINK_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_HALF = BL_W'(BLINK_CYCLES);

    logic mode_p, up_p, down_p;

    edit_state_e       state_q, state_d;
    logic [HOUR_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]  minutes_q, minutes_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [BL_W-1:0]   bl_q, bl_d;

    logic in_edit, any_key, step_ok;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_n    (key_mode_n),
        .press    (mode_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_n    (key_up_n),
        .press    (up_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_n    (key_down_n),
        .press    (down_p)
    );

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            hours_q   <= '0;
            minutes_q <= '0;
            to_q      <= '0;
            bl_q      <= '0;
        end else begin
            state_q   <= state_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            to_q      <= to_d;
            bl_q      <= bl_d;
        end
    end

    assign in_edit = (state_q == ST_EDIT_HOUR) || (state_q == ST_EDIT_MIN);
    assign any_key = mode_p | up_p | down_p;
    // Mode beats a step; opposing up+down cancel each other.
    assign step_ok = in_edit && !mode_p && (up_p ^ down_p);

    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        to_d      = '0;
        bl_d      = (bl_q == BL_LAST) ? '0 : bl_q + 1'b1;

        case (state_q)
            ST_RUN: begin
                bl_d = '0;
                if (mode_p) begin
                    state_d   = ST_EDIT_HOUR;
                    hours_d   = cur_hours;
                    minutes_d = cur_minutes;
                end
            end
            ST_EDIT_HOUR, ST_EDIT_MIN: begin
                to_d = any_key ? '0 : to_q + 1'b1;
                if (mode_p) begin
                    state_d = (state_q == ST_EDIT_HOUR) ? ST_EDIT_MIN : ST_COMMIT;
                    bl_d    = '0;
                end else if (step_ok) begin
                    bl_d = '0;
                    if (state_q == ST_EDIT_HOUR)
                        hours_d = step_hour(hours_q, up_p);
                    else
                        minutes_d = step_min(minutes_q, up_p);
                end else if (!any_key && (to_q == TO_LAST)) begin
                    state_d = ST_RUN;
                end
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign load          = (state_q == ST_COMMIT);
    assign load_hours    = hours_q;
    assign load_minutes  = minutes_q;
    assign editing       = in_edit;
    assign blank_hours   = (state_q == ST_EDIT_HOUR) && (bl_q >= BL_HALF);
    assign blank_minutes = (state_q == ST_EDIT_MIN)  && (bl_q >= BL_HALF);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed key presses, with expected load
// values queued by the stimulus side and checked by an independent load monitor.
module tb_time_set_ctrl;

    localparam int DEB   = 4;
    localparam int BLINK = 8;
    localparam int TMO   = 64;

    localparam logic [2:0] K_MODE = 3'b100;
    localparam logic [2:0] K_UP   = 3'b010;
    localparam logic [2:0] K_DOWN = 3'b001;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic       key_mode_n, key_up_n, key_down_n;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       load;
    logic [4:0] load_hours;
    logic [5:0] load_minutes;
    logic       editing, blank_hours, blank_minutes;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];

    time_set_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_CYCLES    (BLINK),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .rst_n         (rst_n),
        .key_mode_n    (key_mode_n),
        .key_up_n      (key_up_n),
        .key_down_n    (key_down_n),
        .cur_hours     (cur_hours),
        .cur_minutes   (cur_minutes),
        .load          (load),
        .load_hours    (load_hours),
        .load_minutes  (load_minutes),
        .editing       (editing),
        .blank_hours   (blank_hours),
        .blank_minutes (blank_minutes)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Press the selected keys together cleanly, then release long enough to re-arm.
    task automatic applyStimulus(input logic [2:0] keys);
        @(negedge CLOCK_50);
        key_mode_n = ~keys[2];
        key_up_n   = ~keys[1];
        key_down_n = ~keys[0];
        repeat (8) @(negedge CLOCK_50);
        key_mode_n = 1'b1;
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        repeat (8) @(negedge CLOCK_50);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] all_outputs();
        return {1'b0, load, load_hours, load_minutes, editing, blank_hours, blank_minutes};
    endfunction

    // Load monitor: every strobe must match the head of the expectation queue.
    initial begin : monitor
        logic        prev_load;
        logic        prev_editing;
        logic [10:0] exp;
        prev_load    = 1'b0;
        prev_editing = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (!rst_n) begin
                prev_load    = 1'b0;
                prev_editing = 1'b0;
            end else begin
                if (prev_load) begin
                    checks++;
                    if (load !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL load_width actual=%b required=0", load);
                    end
                end
                if (load === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_load actual=%0d:%0d required=none",
                                 load_hours, load_minutes);
                    end else begin
                        exp = exp_q.pop_front();
                        if ({load_hours, load_minutes} !== exp) begin
                            errors++;
                            $display("[TB] FAIL load_value actual=%0d:%0d required=%0d:%0d",
                                     load_hours, load_minutes, exp[10:6], exp[5:0]);
                        end
                    end
                    checks++;
                    if (editing !== 1'b0 || prev_editing !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL editing_at_load actual=%b%b required=10",
                                 prev_editing, editing);
                    end
                end
                prev_load    = load;
                prev_editing = editing;
            end
        end
    end

    initial begin : stimulus
        int cnt;
        int bh_seen;
        int bm_seen;
        int ed_low;
        rst_n       = 1'b0;
        key_mode_n  = 1'b1;
        key_up_n    = 1'b1;
        key_down_n  = 1'b1;
        cur_hours   = 5'd0;
        cur_minutes = 6'd0;

        // Reset and idle
        #1;
        checkOutput("reset_outputs", all_outputs(), 16'h0);
        repeat (3) @(negedge CLOCK_50);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (all_outputs() !== 16'h0) cnt++;
        end
        checkOutput("idle_100_cycles", 16'(cnt), 16'd0);

        // 12:34 -> 15:59
        $display("[TB] test 2: edit 12:34 to 15:59");
        cur_hours   = 5'd12;
        cur_minutes = 6'd34;
        applyStimulus(K_MODE);
        checkOutput("enter_edit_value", {5'd0, load_hours, load_minutes}, {5'd0, 5'd12, 6'd34});
        checkOutput("enter_edit_flag", {15'd0, editing}, 16'd1);
        repeat (3) applyStimulus(K_UP);
        checkOutput("hour_after_up3", {11'd0, load_hours}, 16'd15);
        applyStimulus(K_MODE);
        repeat (35) applyStimulus(K_DOWN);
        checkOutput("min_after_down35", {10'd0, load_minutes}, 16'd59);
        exp_q.push_back({5'd15, 6'd59});
        applyStimulus(K_MODE);
        checkOutput("run_after_commit", {15'd0, editing}, 16'd0);

        // Bouncing mode key must advance exactly once
        $display("[TB] test 3: bounced mode key");
        cur_hours   = 5'd3;
        cur_minutes = 6'd3;
        @(negedge CLOCK_50);
        for (int i = 0; i < 10; i++) begin
            key_mode_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge CLOCK_50);
        end
        key_mode_n = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        key_mode_n = 1'b1;
        bh_seen = 0;
        bm_seen = 0;
        ed_low  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (blank_hours)   bh_seen++;
            if (blank_minutes) bm_seen++;
            if (!editing)      ed_low++;
        end
        checkOutput("bounce_in_edit", 16'(ed_low), 16'd0);
        checkOutput("bounce_hour_blinks", {15'd0, bh_seen != 0}, 16'd1);
        checkOutput("bounce_not_min_field", 16'(bm_seen), 16'd0);
        cnt = 0;
        while (editing === 1'b1 && cnt < 200) begin
            @(negedge CLOCK_50);
            cnt++;
        end
        checkOutput("bounce_timeout_exit", {15'd0, editing}, 16'd0);

        // Wrap-around in both fields
        $display("[TB] test 4: wrap 23:00 to 00:59");
        cur_hours   = 5'd23;
        cur_minutes = 6'd0;
        applyStimulus(K_MODE);
        applyStimulus(K_UP);
        checkOutput("hour_wrap_up", {11'd0, load_hours}, 16'd0);
        applyStimulus(K_MODE);
        applyStimulus(K_DOWN);
        checkOutput("min_wrap_down", {10'd0, load_minutes}, 16'd59);
        exp_q.push_back({5'd0, 6'd59});
        applyStimulus(K_MODE);

        // Timeout length measured from the first edit cycle
        $display("[TB] test 5: timeout and up+down");
        cur_hours   = 5'd9;
        cur_minutes = 6'd9;
        @(negedge CLOCK_50);
        key_mode_n = 1'b0;
        cnt = 0;
        while (editing !== 1'b1 && cnt < 20) begin
            @(negedge CLOCK_50);
            cnt++;
        end
        checkOutput("timeout_entry_seen", {15'd0, editing}, 16'd1);
        key_mode_n = 1'b1;
        cnt = 1;
        while (editing === 1'b1 && cnt < 200) begin
            @(negedge CLOCK_50);
            if (editing === 1'b1) cnt++;
        end
        checkOutput("timeout_edit_cycles", 16'(cnt), 16'(TMO));
        repeat (10) @(negedge CLOCK_50);

        cur_hours   = 5'd5;
        cur_minutes = 6'd10;
        applyStimulus(K_MODE);
        applyStimulus(K_UP | K_DOWN);
        checkOutput("updown_cancel", {11'd0, load_hours}, 16'd5);
        applyStimulus(K_MODE);
        exp_q.push_back({5'd5, 6'd10});
        applyStimulus(K_MODE);

        // Minute field blink, then reset mid-edit
        $display("[TB] test 6: minute blink and reset during edit");
        cur_hours   = 5'd7;
        cur_minutes = 6'd45;
        applyStimulus(K_MODE);
        @(negedge CLOCK_50);
        key_mode_n = 1'b0;
        repeat (6) @(posedge CLOCK_50);
        for (int i = 0; i < 24; i++) begin
            @(negedge CLOCK_50);
            checkOutput($sformatf("blink_min_%0d", i),
                        {14'd0, blank_hours, blank_minutes},
                        {14'd0, 1'b0, 1'(((i / BLINK) % 2) == 1)});
        end
        checkOutput("blink_still_editing", {15'd0, editing}, 16'd1);
        rst_n      = 1'b0;
        key_mode_n = 1'b1;
        #1;
        checkOutput("reset_mid_edit", all_outputs(), 16'h0);
        repeat (3) @(negedge CLOCK_50);
        rst_n = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        checkOutput("after_reset_idle", all_outputs(), 16'h0);

        checkOutput("loads_outstanding", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
